// File: rtl/alu_result_stage.sv
// Registered adder result stage with MIPS overflow trap, epc capture and trap counter.
// One cycle of latency; a 2-entry skid (head + skid) keeps in_ready registered under out_ready stalls.
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int RW    = 5,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_S,
    input  logic             in_Z,
    input  logic             in_V,
    input  logic             in_N,
    input  logic             in_Sign,
    input  logic [RW-1:0]    in_rd,
    input  logic             in_wr,
    input  logic [WIDTH-1:0] in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_S,
    output logic             out_Z,
    output logic             out_N,
    output logic [RW-1:0]    out_rd,
    output logic             out_wr,
    output logic             out_exc,
    output logic [WIDTH-1:0] epc,
    output logic [CW-1:0]    ovf_count
);

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] s;
        logic             z;
        logic             n;
        logic [RW-1:0]    rd;
        logic             wr;
        logic             exc;
    } entry_t;

    entry_t          head_q, head_d;
    entry_t          skid_q, skid_d;
    entry_t          in_ent;
    logic            head_vld_q, head_vld_d;
    logic            skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            accept;
    logic            deliver;
    logic            head_free;

    // Trap decision is made once, at acceptance; unsigned ops never trap.
    always_comb begin
        in_ent     = '0;
        in_ent.pc  = in_pc;
        in_ent.s   = in_S;
        in_ent.z   = in_Z;
        in_ent.n   = in_N;
        in_ent.rd  = in_rd;
        in_ent.exc = in_Sign & in_V;
        in_ent.wr  = in_wr & ~(in_Sign & in_V);
    end

    assign accept    = in_valid & ~skid_vld_q & ~flush;
    assign deliver   = head_vld_q & out_ready;
    assign head_free = ~head_vld_q | out_ready;

    always_comb begin
        head_d     = head_q;
        skid_d     = skid_q;
        head_vld_d = head_vld_q;
        skid_vld_d = skid_vld_q;
        epc_d      = epc_q;
        cnt_d      = cnt_q;

        // A delivery in the flush cycle still counts as delivered.
        if (deliver && head_q.exc) begin
            epc_d = head_q.pc;
            if (cnt_q != {CW{1'b1}}) begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (flush) begin
            head_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (head_free) begin
            // accept is impossible while skid is occupied, so no input lands here then.
            if (skid_vld_q) begin
                head_d     = skid_q;
                head_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                head_d     = in_ent;
                head_vld_d = 1'b1;
            end else begin
                head_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = in_ent;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            skid_q     <= '0;
            head_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            epc_q      <= '0;
            cnt_q      <= '0;
        end else begin
            head_q     <= head_d;
            skid_q     <= skid_d;
            head_vld_q <= head_vld_d;
            skid_vld_q <= skid_vld_d;
            epc_q      <= epc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = ~skid_vld_q;
    assign out_valid = head_vld_q;
    assign out_S     = head_q.s;
    assign out_Z     = head_q.z;
    assign out_N     = head_q.n;
    assign out_rd    = head_q.rd;
    assign out_wr    = head_q.wr;
    assign out_exc   = head_q.exc;
    assign epc       = epc_q;
    assign ovf_count = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized and directed bench for alu_result_stage against a queue-based reference model.
module tb_alu_result_stage;
    localparam int WIDTH = 32;
    localparam int RW    = 5;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_S;
    logic             in_Z, in_V, in_N, in_Sign;
    logic [RW-1:0]    in_rd;
    logic             in_wr;
    logic [WIDTH-1:0] in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_S;
    logic             out_Z, out_N;
    logic [RW-1:0]    out_rd;
    logic             out_wr, out_exc;
    logic [WIDTH-1:0] epc;
    logic [CW-1:0]    ovf_count;

    alu_result_stage #(.WIDTH(WIDTH), .RW(RW), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_S(in_S), .in_Z(in_Z), .in_V(in_V), .in_N(in_N), .in_Sign(in_Sign),
        .in_rd(in_rd), .in_wr(in_wr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_S(out_S), .out_Z(out_Z), .out_N(out_N), .out_rd(out_rd),
        .out_wr(out_wr), .out_exc(out_exc), .epc(epc), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             z;
        logic             n;
        logic [RW-1:0]    rd;
        logic             wr;
        logic             exc;
        logic [WIDTH-1:0] pc;
    } ent_t;

    ent_t             q[$];
    logic [WIDTH-1:0] m_epc;
    int               m_cnt;
    int               n_cmp = 0;
    int               n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input logic [WIDTH-1:0] s, input bit z, input bit vv,
                         input bit n, input bit sg, input logic [RW-1:0] rd, input bit wr,
                         input logic [WIDTH-1:0] pc);
        in_valid = v; in_S = s; in_Z = z; in_V = vv; in_N = n;
        in_Sign = sg; in_rd = rd; in_wr = wr; in_pc = pc;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    // FIFO of at most two results; delivery pops, acceptance pushes, flush empties.
    task automatic model_edge();
        bit   deliver;
        bit   acc;
        ent_t e;
        deliver = (q.size() > 0) && out_ready;
        acc     = in_valid && (q.size() < 2) && !flush;
        if (deliver) begin
            e = q.pop_front();
            if (e.exc) begin
                m_epc = e.pc;
                if (m_cnt < CMAX) m_cnt++;
            end
        end
        if (flush) begin
            q.delete();
        end else if (acc) begin
            e.s   = in_S;
            e.z   = in_Z;
            e.n   = in_N;
            e.rd  = in_rd;
            e.pc  = in_pc;
            e.exc = in_Sign && in_V;
            e.wr  = in_wr && !(in_Sign && in_V);
            q.push_back(e);
        end
    endtask

    task automatic check_all();
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() != 0);
        chk("epc", epc, m_epc);
        chk("ovf_count", ovf_count, m_cnt);
        if (q.size() != 0) begin
            chk("out_S", out_S, q[0].s);
            chk("out_Z", out_Z, q[0].z);
            chk("out_N", out_N, q[0].n);
            chk("out_rd", out_rd, q[0].rd);
            chk("out_wr", out_wr, q[0].wr);
            chk("out_exc", out_exc, q[0].exc);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        idle();
        q.delete(); m_epc = '0; m_cnt = 0;
        #1;
        check_all();
        chk("rst_out_S", out_S, 0);
        chk("rst_out_wr", out_wr, 0);
        chk("rst_out_exc", out_exc, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Pass-through
        out_ready = 1'b1;
        drive(1, 32'h5, 0, 0, 0, 1, 5'd3, 1, 32'h0040_0000);
        step();
        chk("pt_valid", out_valid, 1);
        chk("pt_S", out_S, 32'h5);
        chk("pt_wr", out_wr, 1);
        chk("pt_rd", out_rd, 3);
        chk("pt_exc", out_exc, 0);

        // Signed overflow trap
        drive(1, 32'h8000_0000, 0, 1, 1, 1, 5'd7, 1, 32'h0040_0010);
        step();
        chk("ovf_wr", out_wr, 0);
        chk("ovf_exc", out_exc, 1);
        idle();
        step();
        chk("ovf_epc", epc, 32'h0040_0010);
        chk("ovf_cnt", ovf_count, 1);

        // Unsigned op with V set does not trap
        drive(1, 32'h0, 1, 1, 0, 0, 5'd4, 1, 32'h0040_0020);
        step();
        chk("u_wr", out_wr, 1);
        chk("u_Z", out_Z, 1);
        chk("u_exc", out_exc, 0);
        idle();
        step();
        chk("u_cnt", ovf_count, 1);

        // Backpressure: A head, B skid, C held upstream
        out_ready = 1'b0;
        drive(1, 32'hAAAA_0001, 0, 0, 0, 1, 5'd1, 1, 32'h100);
        step();
        drive(1, 32'hBBBB_0002, 0, 0, 0, 1, 5'd2, 1, 32'h104);
        step();
        drive(1, 32'hCCCC_0003, 0, 0, 0, 1, 5'd5, 1, 32'h108);
        step();
        chk("bp_in_ready", in_ready, 0);
        chk("bp_head_A", out_S, 32'hAAAA_0001);
        out_ready = 1'b1;
        step();
        chk("bp_head_B", out_S, 32'hBBBB_0002);
        step();
        chk("bp_head_C", out_S, 32'hCCCC_0003);
        idle();
        step();
        chk("bp_drained", out_valid, 0);

        // Flush with two held entries and a concurrent offer
        out_ready = 1'b0;
        drive(1, 32'h1111_1111, 0, 1, 0, 1, 5'd9, 1, 32'hDEAD_0000);
        step();
        drive(1, 32'h2222_2222, 0, 0, 0, 1, 5'd10, 1, 32'hDEAD_0004);
        step();
        drive(1, 32'h3333_3333, 0, 0, 0, 1, 5'd11, 1, 32'hDEAD_0008);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        chk("fl_epc", epc, 32'h0040_0010);
        chk("fl_cnt", ovf_count, 1);
        idle();
        out_ready = 1'b1;
        step();
        chk("fl_no_ghost", out_valid, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  RW'($urandom), $urandom_range(0, 1), $urandom);
            out_ready = $urandom_range(0, 9) < 7;
            flush     = $urandom_range(0, 19) == 0;
            step();
        end
        flush = 1'b0;
        idle();
        out_ready = 1'b1;
        step();
        step();

        // Saturation: five traps delivered back to back
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h7FFF_FFF0 + i, 0, 1, 0, 1, 5'd12, 1, 32'h0050_0000 + 4 * i);
            step();
        end
        idle();
        step();
        chk("sat_cnt", ovf_count, 3);
        chk("sat_epc", epc, 32'h0050_0010);

        // Reset asserted while stalled
        out_ready = 1'b0;
        drive(1, 32'h4444_4444, 0, 1, 0, 1, 5'd13, 1, 32'h0060_0000);
        step();
        drive(1, 32'h5555_5555, 0, 1, 0, 1, 5'd14, 1, 32'h0060_0004);
        step();
        idle();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_epc", epc, 0);
        chk("rst_cnt", ovf_count, 0);
        chk("rst_in_ready", in_ready, 1);
        q.delete(); m_epc = '0; m_cnt = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 32-bit adder. Captures sum S and flags Z/V/N plus instruction context.
- Applies MIPS overflow-trap semantics: a signed add with V=1 suppresses register write and raises an exception toward the controller.
- Presents the result to the MEM/WB side over a valid/ready handshake, using a 2-entry skid buffer so that in_ready is a registered signal.

Parameters:
WIDTH, 32, datapath width of S and PC
RW, 5, destination register index width
CW, 8, overflow event counter width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  upstream result valid
in_ready  output  1  stage can accept (registered)
in_S  input  WIDTH  adder sum
in_Z  input  1  zero flag
in_V  input  1  overflow flag
in_N  input  1  negative flag
in_Sign  input  1  1 = signed op (add), 0 = unsigned (addu)
in_rd  input  RW  destination register
in_wr  input  1  instruction writes rd
in_pc  input  WIDTH  PC of the instruction
flush  input  1  synchronous kill of all held entries
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts
out_S  output  WIDTH  head sum
out_Z  output  1  head zero flag
out_N  output  1  head negative flag
out_rd  output  RW  head destination
out_wr  output  1  head write enable (0 if trapped)
out_exc  output  1  head entry is an overflow trap
epc  output  WIDTH  PC of the last delivered trapping instruction
ovf_count  output  CW  saturating count of delivered traps

Behaviour:
- Reset (reset=0, async): both entries invalid; in_ready=1; out_valid=0; all out_* data=0; out_exc=0; epc=0; ovf_count=0.
- Accept: in_valid & in_ready at a rising edge. Trap bit computed at acceptance: trap = in_Sign & in_V.
- Stored wr for an accepted entry = in_wr & ~trap. For unsigned ops, V is ignored and never traps.
- Storage: head register (drives out_*) and skid register.
- Accept when head is empty or being drained this cycle -> entry goes to head.
- Accept when head is stalled (out_valid & ~out_ready) -> entry goes to skid.
- Head drains with skid non-empty -> skid moves to head in the same edge.
- in_ready (registered) = ~skid_valid. Entries are never dropped or duplicated.
- Latency: 1 cycle from acceptance to out_valid when the stage is empty. Throughput: 1 entry/cycle with out_ready held at 1.
- Order: strict FIFO between the two entries.
- Delivery: out_valid & out_ready at an edge. If the delivered entry has out_exc=1: epc <= its pc, and ovf_count increments, saturating at 2^CW-1.
- epc and ovf_count never change on non-trap deliveries or on flush.
- out_exc is a direct view of the head trap bit; it is valid only while out_valid=1.
- Flush (synchronous) takes priority over everything in that cycle:
  - both entries become invalid at the next edge;
  - any in_valid offered that cycle is dropped;
  - a delivery coinciding with flush still completes, including its epc/ovf_count update.
  - in_ready = 1 in the cycle after flush.
- Reset asserted mid-transfer: immediate return to reset values; no partial epc/count update.
- out_* data holds its last value while out_valid=0. Benches must not check data when out_valid=0.
- Width rule: S is passed unmodified; there is no sign-extension or masking.

Test Plan:
- Pass-through: in_S=0x00000005, Z=0, V=0, Sign=1, wr=1, rd=3, out_ready=1 -> next cycle out_valid=1, out_S=5, out_wr=1, out_rd=3, out_exc=0.
- Signed overflow: in_S=0x80000000, V=1, Sign=1, wr=1, pc=0x00400010, delivered -> out_wr=0, out_exc=1; after delivery epc=0x00400010, ovf_count=1.
- Unsigned no-trap: Sign=0, V=1, in_S=0x00000000, Z=1, wr=1 -> out_wr=1, out_Z=1, out_exc=0, ovf_count unchanged.
- Backpressure: out_ready=0, stream entries A, B, C -> A in head, B in skid, in_ready=0 so C is held upstream. Raise out_ready -> outputs A, B, C in order, 1 per cycle, none lost.
- Flush: two entries held plus in_valid=1 and flush=1 in one cycle -> next cycle out_valid=0, in_ready=1; the offered entry never appears; epc and ovf_count unchanged.
- Saturation/reset: CW=2, deliver 5 traps -> ovf_count=3. Assert reset mid-stall -> out_valid=0, epc=0, ovf_count=0 immediately.
